// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, pixel formats and FSM states for the frame loader
package display_pkg;

   localparam int PIXEL_WIDTH = 24;

   localparam logic FMT_RGB888 = 1'b0;
   localparam logic FMT_RGB565 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_FLIP_WAIT = 2'd2
   } state_t;

   // Widen 5/6-bit channels by replicating their top bits so full-scale maps to 0xFF.
   function automatic logic [PIXEL_WIDTH-1:0] expand_565(input logic [15:0] w);
      return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
   endfunction

endpackage

// File: rtl/pixel_unpack.sv
// rtl/pixel_unpack.sv - assembles big-endian stream bytes into 24-bit pixels
module pixel_unpack
   import display_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   accept,
   input  logic                   fmt,
   input  logic [7:0]             byte_data,
   output logic                   pix_done,
   output logic [PIXEL_WIDTH-1:0] pix_rgb,
   output logic                   phase_zero_nxt
);

   logic        fmt_q;
   logic [1:0]  phase;
   logic [15:0] hold;
   logic        fmt_eff;
   logic [1:0]  phase_eff;
   logic [1:0]  last_phase;
   logic [1:0]  phase_nxt;

   // A start byte is always byte 0 and uses the format presented with it.
   always_comb begin
      fmt_eff        = start ? fmt : fmt_q;
      phase_eff      = start ? 2'd0 : phase;
      last_phase     = (fmt_eff == FMT_RGB565) ? 2'd1 : 2'd2;
      pix_done       = accept && (phase_eff == last_phase);
      phase_nxt      = phase;
      if (accept) begin
         phase_nxt = pix_done ? 2'd0 : phase_eff + 2'd1;
      end
      phase_zero_nxt = (phase_nxt == 2'd0);
      pix_rgb        = (fmt_eff == FMT_RGB565) ? expand_565({hold[7:0], byte_data})
                                               : {hold, byte_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fmt_q <= FMT_RGB888;
         phase <= 2'd0;
         hold  <= 16'd0;
      end else begin
         if (start) begin
            fmt_q <= fmt;
         end
         if (accept) begin
            phase <= phase_nxt;
            hold  <= {hold[7:0], byte_data};
         end
      end
   end

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - loads a byte-stream frame into display memory and flips banks
module frame_loader
   import display_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int COLUMNS = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fmt,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   input  logic                       in_sot,
   input  logic                       in_eot,
   input  logic                       safe_flip,
   output logic                       wen,
   output logic [$clog2(ROWS)-1:0]    wrow,
   output logic [$clog2(COLUMNS)-1:0] wcol,
   output logic [PIXEL_WIDTH-1:0]     wdata,
   output logic                       flip,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       frame_error
);

   localparam int RB   = $clog2(ROWS);
   localparam int CB   = $clog2(COLUMNS);
   localparam int NPIX = ROWS * COLUMNS;
   localparam int CW   = RB + CB + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(NPIX);

   state_t                 state;
   state_t                 state_nxt;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_base;
   logic [CW-1:0]          cnt_nxt;
   logic                   ovf;
   logic                   ovf_nxt;
   logic                   sot_byte;
   logic                   data_byte;
   logic                   full;
   logic                   accept;
   logic                   eot_eval;
   logic                   frame_good;
   logic                   err_set;
   logic                   flip_set;
   logic                   pix_done;
   logic                   phase_zero_nxt;
   logic [PIXEL_WIDTH-1:0] pix_rgb;

   pixel_unpack u_unpack (
      .clk            (clk),
      .rst            (rst),
      .start          (sot_byte),
      .accept         (accept),
      .fmt            (fmt),
      .byte_data      (in_data),
      .pix_done       (pix_done),
      .pix_rgb        (pix_rgb),
      .phase_zero_nxt (phase_zero_nxt)
   );

   // End-of-frame is judged on the state as it will be after this cycle's byte.
   always_comb begin
      sot_byte   = in_valid && in_sot && (state != ST_FLIP_WAIT);
      data_byte  = in_valid && !in_sot && (state == ST_LOAD);
      full       = (cnt == FULL_CNT);
      accept     = sot_byte || (data_byte && !full);
      cnt_base   = sot_byte ? '0 : cnt;
      cnt_nxt    = cnt_base + CW'(pix_done);
      ovf_nxt    = (sot_byte ? 1'b0 : ovf) || (data_byte && full);
      eot_eval   = in_eot && ((state == ST_LOAD) || sot_byte);
      frame_good = (cnt_nxt == FULL_CNT) && phase_zero_nxt && !ovf_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      flip_set  = 1'b0;
      busy      = (state != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            if (sot_byte) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_LOAD;
         end
         ST_FLIP_WAIT: begin
            if (safe_flip) begin
               state_nxt = ST_IDLE;
               flip_set  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (eot_eval) begin
         if (frame_good) begin
            state_nxt = ST_FLIP_WAIT;
         end else begin
            state_nxt = ST_IDLE;
            err_set   = 1'b1;
         end
      end
   end

   // Pixel address is the pre-increment count, split row-major.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= '0;
         ovf         <= 1'b0;
         wen         <= 1'b0;
         wrow        <= '0;
         wcol        <= '0;
         wdata       <= '0;
         flip        <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         ovf         <= ovf_nxt;
         wen         <= pix_done;
         if (pix_done) begin
            wrow  <= cnt[RB+CB-1:CB];
            wcol  <= cnt[CB-1:0];
            wdata <= pix_rgb;
         end
         flip        <= flip ^ flip_set;
         frame_done  <= flip_set;
         frame_error <= err_set;
      end
   end

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader
module tb_frame_loader;

   localparam int ROWS    = 8;
   localparam int COLUMNS = 32;
   localparam int NPIX    = ROWS * COLUMNS;

   logic        clk = 1'b0;
   logic        rst;
   logic        fmt;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sot;
   logic        in_eot;
   logic        safe_flip;
   logic        wen;
   logic [2:0]  wrow;
   logic [4:0]  wcol;
   logic [23:0] wdata;
   logic        flip;
   logic        busy;
   logic        frame_done;
   logic        frame_error;

   int passed = 0;
   int total  = 0;
   int wen_cnt  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   logic [23:0] cap_data [0:4095];
   logic [2:0]  cap_row  [0:4095];
   logic [4:0]  cap_col  [0:4095];

   frame_loader #(.ROWS(ROWS), .COLUMNS(COLUMNS)) dut (
      .clk         (clk),
      .rst         (rst),
      .fmt         (fmt),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_sot      (in_sot),
      .in_eot      (in_eot),
      .safe_flip   (safe_flip),
      .wen         (wen),
      .wrow        (wrow),
      .wcol        (wcol),
      .wdata       (wdata),
      .flip        (flip),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wen) begin
         cap_data[wen_cnt[11:0]] <= wdata;
         cap_row[wen_cnt[11:0]]  <= wrow;
         cap_col[wen_cnt[11:0]]  <= wcol;
         wen_cnt <= wen_cnt + 1;
      end
      if (frame_done)  done_cnt <= done_cnt + 1;
      if (frame_error) err_cnt  <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic put(input logic v, input logic [7:0] d, input logic s, input logic e);
      in_valid = v;
      in_data  = d;
      in_sot   = s;
      in_eot   = e;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic f, input int nbytes, input logic do_eot);
      fmt = f;
      for (int i = 0; i < nbytes; i++) put(1'b1, 8'(i), (i == 0), 1'b0);
      if (do_eot) put(1'b0, 8'h00, 1'b0, 1'b1);
      idle(4);
   endtask

   task automatic check_888(input int base, input string tag);
      int bad;
      int idx;
      logic [23:0] e;
      bad = 0;
      for (int k = 0; k < NPIX; k++) begin
         idx = (base + k) % 4096;
         e   = {8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)};
         if (cap_row[idx] !== 3'(k / COLUMNS) || cap_col[idx] !== 5'(k % COLUMNS) ||
             cap_data[idx] !== e) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic wait_done(input int base, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (done_cnt > base) ok = 1'b1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   b;
      int   bd;
      int   be;
      logic ok;

      rst = 1'b0; fmt = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      in_sot = 1'b0; in_eot = 1'b0; safe_flip = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wen", wen, 0);
      check("rst_busy", busy, 0);
      check("rst_flip", flip, 0);
      check("rst_done", frame_done, 0);
      check("rst_err", frame_error, 0);
      check("rst_wrow", wrow, 0);
      check("rst_wcol", wcol, 0);
      check("rst_wdata", wdata, 0);
      rst = 1'b1;
      @(negedge clk);

      b = wen_cnt;
      for (int i = 0; i < 6; i++) put(1'b1, 8'h11, 1'b0, 1'b0);
      idle(3);
      check("pre_sot_wen", wen_cnt - b, 0);
      check("pre_sot_busy", busy, 0);

      // full RGB888 frame
      b = wen_cnt; bd = done_cnt; be = err_cnt;
      send_frame(1'b0, 768, 1'b1);
      check("f888_wen", wen_cnt - b, 256);
      check_888(b, "f888_pixels");
      check("f888_last_row", cap_row[(b + 255) % 4096], 7);
      check("f888_last_col", cap_col[(b + 255) % 4096], 31);
      check("f888_flip", flip, 1);
      check("f888_done", done_cnt - bd, 1);
      check("f888_err", err_cnt - be, 0);
      check("f888_busy", busy, 0);

      // RGB565 expansion; fmt changes mid-frame must be ignored
      b = wen_cnt; be = err_cnt;
      fmt = 1'b1;
      put(1'b1, 8'hF8, 1'b1, 1'b0);
      fmt = 1'b0;
      put(1'b1, 8'h00, 1'b0, 1'b0);
      put(1'b1, 8'h07, 1'b0, 1'b0); put(1'b1, 8'hE0, 1'b0, 1'b0);
      put(1'b1, 8'h00, 1'b0, 1'b0); put(1'b1, 8'h1F, 1'b0, 1'b0);
      put(1'b1, 8'h84, 1'b0, 1'b0); put(1'b1, 8'h10, 1'b0, 1'b0);
      put(1'b0, 8'h00, 1'b0, 1'b1);
      idle(4);
      check("f565_wen", wen_cnt - b, 4);
      check("f565_red", cap_data[b % 4096], 24'hFF0000);
      check("f565_green", cap_data[(b + 1) % 4096], 24'h00FF00);
      check("f565_blue", cap_data[(b + 2) % 4096], 24'h0000FF);
      check("f565_mid", cap_data[(b + 3) % 4096], 24'h848284);
      check("f565_col3", cap_col[(b + 3) % 4096], 3);
      check("f565_err", err_cnt - be, 1);
      check("f565_flip", flip, 1);

      // short frame
      b = wen_cnt; bd = done_cnt; be = err_cnt;
      send_frame(1'b0, 100, 1'b1);
      check("short_wen", wen_cnt - b, 33);
      check("short_err", err_cnt - be, 1);
      check("short_flip", flip, 1);
      check("short_busy", busy, 0);
      check("short_done", done_cnt - bd, 0);

      // one byte too many
      b = wen_cnt; bd = done_cnt; be = err_cnt;
      send_frame(1'b0, 769, 1'b1);
      check("ovf_wen", wen_cnt - b, 256);
      check("ovf_err", err_cnt - be, 1);
      check("ovf_flip", flip, 1);
      check("ovf_done", done_cnt - bd, 0);
      check("ovf_busy", busy, 0);

      // eot in IDLE ignored; sot+eot together is an error
      be = err_cnt;
      put(1'b0, 8'h00, 1'b0, 1'b1);
      idle(3);
      check("idle_eot_err", err_cnt - be, 0);
      b = wen_cnt;
      put(1'b1, 8'h55, 1'b1, 1'b1);
      idle(3);
      check("one_byte_err", err_cnt - be, 1);
      check("one_byte_wen", wen_cnt - b, 0);
      check("one_byte_busy", busy, 0);

      // asynchronous reset mid-frame
      fmt = 1'b0;
      for (int i = 0; i < 300; i++) put(1'b1, 8'(i), (i == 0), 1'b0);
      check("pre_rst_wen", wen, 1);
      check("pre_rst_busy", busy, 1);
      in_valid = 1'b0; in_sot = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_wen", wen, 0);
      check("arst_busy", busy, 0);
      check("arst_flip", flip, 0);
      check("arst_wrow", wrow, 0);
      check("arst_wcol", wcol, 0);
      check("arst_wdata", wdata, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      b = wen_cnt;
      for (int i = 0; i < 6; i++) put(1'b1, 8'h22, 1'b0, 1'b0);
      idle(3);
      check("post_rst_drop", wen_cnt - b, 0);
      b = wen_cnt; bd = done_cnt;
      send_frame(1'b0, 768, 1'b1);
      check("post_rst_wen", wen_cnt - b, 256);
      check("post_rst_row0", cap_row[b % 4096], 0);
      check("post_rst_col0", cap_col[b % 4096], 0);
      check_888(b, "post_rst_pixels");
      check("post_rst_flip", flip, 1);
      check("post_rst_done", done_cnt - bd, 1);

      // good RGB565 frame held in FLIP_WAIT
      b = wen_cnt; bd = done_cnt;
      safe_flip = 1'b0;
      send_frame(1'b1, 512, 1'b1);
      check("hold_busy0", busy, 1);
      check("hold_wen", wen_cnt - b, 256);
      check("hold_last_data", cap_data[(b + 255) % 4096], 24'hFFDFFF);
      check("hold_last_row", cap_row[(b + 255) % 4096], 7);
      check("hold_last_col", cap_col[(b + 255) % 4096], 31);
      put(1'b1, 8'hAA, 1'b1, 1'b0);
      put(1'b1, 8'hBB, 1'b0, 1'b0);
      put(1'b1, 8'hCC, 1'b0, 1'b0);
      put(1'b1, 8'hDD, 1'b0, 1'b0);
      idle(46);
      check("hold_busy1", busy, 1);
      check("hold_flip", flip, 1);
      check("hold_sot_ignored", wen_cnt - b, 256);
      check("hold_no_done", done_cnt - bd, 0);
      safe_flip = 1'b1;
      wait_done(bd, ok);
      check("hold_done_seen", ok, 1);
      idle(2);
      check("hold_flip_after", flip, 0);
      check("hold_busy_after", busy, 0);
      check("hold_done_once", done_cnt - bd, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter ROWS, default 8: display rows; must be a power of two, at least 2.
REQ-002 Parameter COLUMNS, default 32: display columns; must be a power of two, at least 2.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port fmt, input, 1: pixel format, 0 = RGB888 (3 bytes/pixel), 1 = RGB565 (2 bytes/pixel); sampled only on the sot byte.
REQ-006 Port in_data, input, 8: stream byte.
REQ-007 Port in_valid, input, 1: in_data valid this cycle.
REQ-008 Port in_sot, input, 1: qualified by in_valid; marks the first byte of a frame.
REQ-009 Port in_eot, input, 1: end of frame; not qualified by in_valid.
REQ-010 Port safe_flip, input, 1: driver is between scans, so a bank swap is safe.
REQ-011 Port wen, output, 1: memory write strobe.
REQ-012 Port wrow, output, clog2(ROWS): write row.
REQ-013 Port wcol, output, clog2(COLUMNS): write column.
REQ-014 Port wdata, output, 24: pixel as {R[23:16], G[15:8], B[7:0]}.
REQ-015 Port flip, output, 1: memory bank select level.
REQ-016 Port busy, output, 1: high in LOAD and FLIP_WAIT.
REQ-017 Port frame_done, output, 1: one-cycle pulse.
REQ-018 Port frame_error, output, 1: one-cycle pulse.

Function
REQ-019 States: IDLE, LOAD, FLIP_WAIT.
REQ-020 IDLE/LOAD + in_valid & in_sot: latch fmt; clear byte phase, pixel count, overflow flag; treat the byte as byte 0 of pixel 0; go to LOAD (restart if already in LOAD).
REQ-021 LOAD + in_valid without in_sot: accept the byte as the next byte of the current pixel.
REQ-022 IDLE + in_valid without in_sot: byte discarded.
REQ-023 FLIP_WAIT: all input ignored, including in_sot.
REQ-024 Bytes are big-endian within a pixel (first byte is most significant).
REQ-025 RGB565 expansion: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
REQ-026 Pixel order is row-major from row 0, column 0: column increments first; column wraps COLUMNS-1 -> 0 and row increments.
REQ-027 wen is high for exactly one cycle, the cycle after the last byte of a pixel is accepted; wrow, wcol and wdata are valid in that cycle.
REQ-028 Once ROWS*COLUMNS pixels have been written, further bytes are dropped (no wen) and the overflow flag is set.
REQ-029 in_eot in LOAD is evaluated after any same-cycle byte is accepted.
REQ-030 in_eot in LOAD with count == ROWS*COLUMNS, byte phase 0 and overflow clear -> FLIP_WAIT.
REQ-031 in_eot in LOAD in any other case -> frame_error pulse next cycle, go to IDLE, flip unchanged.
REQ-032 in_eot in IDLE or FLIP_WAIT is ignored.
REQ-033 in_sot and in_eot in the same valid cycle form a one-byte frame, which produces frame_error.
REQ-034 FLIP_WAIT + safe_flip high: toggle flip and pulse frame_done on the same edge, then go to IDLE.
REQ-035 FLIP_WAIT samples safe_flip no earlier than the cycle after entry.

Reset
REQ-036 rst low: state = IDLE; wen, busy, frame_done, frame_error, flip, wrow, wcol, wdata, counters and overflow flag all 0; takes effect immediately, mid-frame included.
REQ-037 After rst deassertion, bytes arriving before a new in_sot are discarded.

Structure
REQ-038 Package display_pkg holds: PIXEL_WIDTH=24, fmt encodings FMT_RGB888/FMT_RGB565, and the state enum.
REQ-039 Sub-module pixel_unpack performs byte assembly and 565 expansion and emits a pixel-valid pulse; frame_loader holds the FSM and the address counters.

Verification
REQ-040 RGB888 with defaults: sot, 768 bytes, eot, safe_flip high -> 256 wen pulses; last write row 7, col 31; flip 0->1; one frame_done.
REQ-041 RGB565 bytes 0xF8,0x00 -> wdata 0xFF0000; bytes 0x07,0xE0 -> wdata 0x00FF00.
REQ-042 eot after 100 bytes (RGB888) -> frame_error pulse, flip unchanged, busy low.
REQ-043 769 bytes (RGB888) -> 256 wen pulses, then frame_error at eot, no flip.
REQ-044 safe_flip held low for 50 cycles after a good eot -> busy high and no flip; a sot sent meanwhile is ignored; raising safe_flip -> flip toggles.
REQ-045 rst asserted after 300 bytes -> all outputs 0 asynchronously; next full frame loads from row 0, col 0.
